// File: rtl/if_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_stage_pkg
// Shared definitions for the instruction-fetch stage and its neighbours.
//   - PC_* : decode redirect encodings carried on pc_sel (also used by decoder)
//   - if_state_e : fetch controller states
//   - NOP : bubble opcode presented to decode when no instruction is valid
// -----------------------------------------------------------------------------
package if_stage_pkg;

    localparam int WORD_W = 16;

    localparam logic [1:0] PC_SEQ  = 2'b00;
    localparam logic [1:0] PC_BR8  = 2'b01;
    localparam logic [1:0] PC_J11  = 2'b10;
    localparam logic [1:0] PC_HALT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2,
        HALT = 2'd3
    } if_state_e;

    localparam logic [WORD_W-1:0] NOP = 16'h0000;

endpackage

// File: rtl/if_stage_if.sv
// -----------------------------------------------------------------------------
// if_stage_if
// Single-outstanding request/ack instruction-memory port.
//   req   : fetch request (fetch -> memory)
//   addr  : word address, held while req=1 and ack=0 (fetch -> memory)
//   ack   : rdata valid this cycle, request complete (memory -> fetch)
//   rdata : instruction word (memory -> fetch)
// -----------------------------------------------------------------------------
interface if_stage_if;
    import if_stage_pkg::*;

    logic              req;
    logic [WORD_W-1:0] addr;
    logic              ack;
    logic [WORD_W-1:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/if_stage_target_calc.sv
// -----------------------------------------------------------------------------
// if_target_calc
// Combinational redirect decode for the fetch stage.
//   id_base_i  : pc_next of the instruction currently held in the decode IR
//   pc_sel_i   : 00 seq, 01 branch8, 10 jump11, 11 halt
//   jr_sel_i   : register jump, takes priority over pc_sel_i
//   jmp8_i / jmp11_i : sign-extended relative offsets
//   jmpr_i     : absolute register-jump target
//   target_o   : new fetch address (16-bit wrap-around arithmetic)
//   halt_o     : redirect is a halt rather than a jump
//   redirect_o : any redirect requested this cycle
// -----------------------------------------------------------------------------
module if_target_calc
    import if_stage_pkg::*;
(
    input  logic [WORD_W-1:0] id_base_i,
    input  logic [1:0]        pc_sel_i,
    input  logic              jr_sel_i,
    input  logic [WORD_W-1:0] jmp8_i,
    input  logic [WORD_W-1:0] jmp11_i,
    input  logic [WORD_W-1:0] jmpr_i,
    output logic [WORD_W-1:0] target_o,
    output logic              halt_o,
    output logic              redirect_o
);

    always_comb begin
        target_o   = id_base_i;
        halt_o     = 1'b0;
        redirect_o = jr_sel_i | (pc_sel_i != PC_SEQ);
        if (jr_sel_i) begin
            target_o = jmpr_i;
        end else begin
            case (pc_sel_i)
                PC_BR8:  target_o = id_base_i + jmp8_i;
                PC_J11:  target_o = id_base_i + jmp11_i;
                PC_HALT: halt_o   = 1'b1;
                default: target_o = id_base_i;
            endcase
        end
    end

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage feeding decode. Owns the PC, runs a single
// outstanding request on the instruction-memory port, applies decode
// redirects with one delay slot and inserts NOP bubbles on wait states.
//   clk, rst        : clock, synchronous active-high reset
//   pc_sel, jr_sel  : redirect controls from decode
//   jmp8, jmp11     : sign-extended relative offsets (base = id_base)
//   jmpr            : absolute register-jump target
//   imem            : memory port (master side)
//   op, pc_next     : registered instruction and its address + 1
//   halted          : fetch stopped until reset
// -----------------------------------------------------------------------------
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 16'h0000,
    parameter logic [WORD_W-1:0] NOP_OP   = NOP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        pc_sel,
    input  logic              jr_sel,
    input  logic [WORD_W-1:0] jmp8,
    input  logic [WORD_W-1:0] jmp11,
    input  logic [WORD_W-1:0] jmpr,
    if_stage_if.master        imem,
    output logic [WORD_W-1:0] op,
    output logic [WORD_W-1:0] pc_next,
    output logic              halted
);

    if_state_e         state_q, state_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] op_q, op_d;
    logic [WORD_W-1:0] pc_next_q, pc_next_d;
    logic [WORD_W-1:0] id_base_q;
    logic [WORD_W-1:0] tgt_save_q, tgt_save_d;
    logic              halt_pend_q, halt_pend_d;

    logic [WORD_W-1:0] target;
    logic              tgt_halt;
    logic              redirect;

    // id_base trails pc_next by one cycle, so it names the instruction that
    // decode is looking at right now, which is the base for relative jumps.
    if_target_calc u_target (
        .id_base_i  (id_base_q),
        .pc_sel_i   (pc_sel),
        .jr_sel_i   (jr_sel),
        .jmp8_i     (jmp8),
        .jmp11_i    (jmp11),
        .jmpr_i     (jmpr),
        .target_o   (target),
        .halt_o     (tgt_halt),
        .redirect_o (redirect)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= RESET_PC;
            op_q        <= NOP_OP;
            pc_next_q   <= RESET_PC;
            id_base_q   <= RESET_PC;
            tgt_save_q  <= '0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            op_q        <= op_d;
            pc_next_q   <= pc_next_d;
            id_base_q   <= pc_next_q;
            tgt_save_q  <= tgt_save_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        op_d        = NOP_OP;
        pc_next_d   = pc_next_q;
        tgt_save_d  = tgt_save_q;
        halt_pend_d = halt_pend_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (redirect) begin
                    // The word returned in the redirect cycle is past the
                    // delay slot and is always thrown away.
                    if (imem.ack) begin
                        if (tgt_halt) state_d = HALT;
                        else          addr_d  = target;
                    end else begin
                        // Request still in flight: keep its address on the
                        // bus and remember where to go once it completes.
                        tgt_save_d  = target;
                        halt_pend_d = tgt_halt;
                        state_d     = DROP;
                    end
                end else if (imem.ack) begin
                    op_d      = imem.rdata;
                    pc_next_d = addr_q + 16'd1;
                    addr_d    = addr_q + 16'd1;
                end
            end
            DROP: begin
                if (imem.ack) begin
                    if (halt_pend_q) begin
                        state_d = HALT;
                    end else begin
                        addr_d  = tgt_save_q;
                        state_d = REQ;
                    end
                end
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    assign imem.req  = (state_q == REQ) || (state_q == DROP);
    assign imem.addr = addr_q;
    assign op        = op_q;
    assign pc_next   = pc_next_q;
    assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Fetch-stage bench: directed scenarios followed by randomized memory wait
// states, redirects and resets, checked every cycle against a
// request-lifetime reference model of the fetch stage.
// -----------------------------------------------------------------------------
module tb_if_stage;
    import if_stage_pkg::*;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic [1:0]  pc_sel = 2'b00;
    logic        jr_sel = 1'b0;
    logic [15:0] jmp8   = 16'h0000;
    logic [15:0] jmp11  = 16'h0000;
    logic [15:0] jmpr   = 16'h0000;
    logic [15:0] op;
    logic [15:0] pc_next;
    logic        halted;
    logic        ack_en = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    if_stage_if imem ();

    function automatic logic [15:0] mem_word(logic [15:0] a);
        return 16'h1000 + a;
    endfunction

    assign imem.ack   = ack_en & imem.req;
    assign imem.rdata = mem_word(imem.addr);

    if_stage #(.RESET_PC(16'h0000), .NOP_OP(16'h0000)) dut (
        .clk     (clk),
        .rst     (rst),
        .pc_sel  (pc_sel),
        .jr_sel  (jr_sel),
        .jmp8    (jmp8),
        .jmp11   (jmp11),
        .jmpr    (jmpr),
        .imem    (imem),
        .op      (op),
        .pc_next (pc_next),
        .halted  (halted)
    );

    always #5 clk = ~clk;

    // Reference model: tracks the request on the bus, whether decode has
    // killed it, the delivered instruction stream and the decode IR.
    logic        m_started = 1'b0;
    logic        m_halted  = 1'b0;
    logic [15:0] m_addr    = 16'h0000;
    logic        m_killed  = 1'b0;
    logic [15:0] m_sv_tgt  = 16'h0000;
    logic        m_sv_halt = 1'b0;
    logic [15:0] m_op      = 16'h0000;
    logic [15:0] m_pcn     = 16'h0000;
    logic        m_vld     = 1'b0;
    logic [15:0] m_ir_pcn  = 16'h0000;
    logic        m_ir_vld  = 1'b0;

    function automatic logic m_req();
        return m_started && !m_halted;
    endfunction

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic        ack;
        logic        redir;
        logic        hlt;
        logic [15:0] tgt;
        if (rst) begin
            m_started = 1'b0; m_halted = 1'b0; m_addr = 16'h0000;
            m_killed = 1'b0; m_sv_tgt = 16'h0000; m_sv_halt = 1'b0;
            m_op = 16'h0000; m_pcn = 16'h0000; m_vld = 1'b0;
            m_ir_pcn = 16'h0000; m_ir_vld = 1'b0;
        end else begin
            ack   = ack_en && m_req();
            redir = jr_sel || (pc_sel != 2'b00);
            hlt   = !jr_sel && (pc_sel == 2'b11);
            tgt   = jr_sel ? jmpr : ((pc_sel == 2'b01) ? m_ir_pcn + jmp8 : m_ir_pcn + jmp11);
            m_ir_pcn = m_pcn;
            m_ir_vld = m_vld;
            m_op  = 16'h0000;
            m_vld = 1'b0;
            if (!m_started) begin
                m_started = 1'b1;
            end else if (!m_halted) begin
                if (redir && !m_killed) begin
                    m_killed  = 1'b1;
                    m_sv_tgt  = tgt;
                    m_sv_halt = hlt;
                end
                if (ack) begin
                    if (m_killed) begin
                        if (m_sv_halt) m_halted = 1'b1;
                        else           m_addr   = m_sv_tgt;
                        m_killed = 1'b0;
                    end else begin
                        m_op   = mem_word(m_addr);
                        m_pcn  = m_addr + 16'd1;
                        m_vld  = 1'b1;
                        m_addr = m_addr + 16'd1;
                    end
                end
            end
        end
    endtask

    // Compare process: DUT outputs against the model, every cycle.
    always @(negedge clk) begin
        chk("imem_req",  {15'b0, imem.req}, {15'b0, m_req()});
        chk("imem_addr", imem.addr, m_addr);
        chk("op",        op,        m_op);
        chk("pc_next",   pc_next,   m_pcn);
        chk("halted",    {15'b0, halted}, {15'b0, m_halted});
    end

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_redir();
        pc_sel = 2'b00; jr_sel = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_redir();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_ir_vld();
        int k = 0;
        while (!m_ir_vld && k < 20) begin
            step();
            k++;
        end
        chk("ir_valid_wait", {15'b0, m_ir_vld}, 16'h0001);
    endtask

    initial begin
        logic        prev_redir;
        logic [7:0]  r8;
        logic [10:0] r11;
        int          kind;

        // Reset and zero-wait sequential fetch
        ack_en = 1'b1;
        do_reset();
        chk("lit_rst_op",   m_op,   16'h0000);
        chk("lit_rst_addr", m_addr, 16'h0000);
        chk("lit_rst_req",  {15'b0, m_req()}, 16'h0000);
        step();
        chk("lit_idle_op",  m_op,   16'h0000);
        step();
        chk("lit_first_op", m_op,   16'h1000);
        chk("lit_first_pcn", m_pcn, 16'h0001);
        step();
        chk("lit_second_op", m_op,  16'h1001);

        // Branch8 while addr 4 is in decode: delay slot 5, drop 6, go to 1
        for (int k = 0; k < 20 && !(m_ir_vld && m_ir_pcn == 16'h0005); k++) step();
        chk("lit_br_slot", m_op, 16'h1005);
        pc_sel = 2'b01; jmp8 = 16'hFFFC;
        step();
        clear_redir();
        chk("lit_br_drop",  m_op,   16'h0000);
        chk("lit_br_addr",  m_addr, 16'h0001);
        step();
        chk("lit_br_tgt",   m_op,   16'h1001);
        chk("lit_br_pcn",   m_pcn,  16'h0002);

        // Memory acks every third cycle
        for (int i = 0; i < 18; i++) begin
            ack_en = (i % 3 == 2);
            step();
        end
        ack_en = 1'b1;

        // Register jump with ack withheld two cycles
        do_reset();
        step(); step(); step();
        chk("lit_jr_irv", {15'b0, m_ir_vld}, 16'h0001);
        ack_en = 1'b0; jr_sel = 1'b1; jmpr = 16'h0040;
        step();
        clear_redir();
        chk("lit_jr_hold1", m_addr, 16'h0002);
        step();
        chk("lit_jr_hold2", m_addr, 16'h0002);
        ack_en = 1'b1;
        step();
        chk("lit_jr_addr",  m_addr, 16'h0040);
        chk("lit_jr_nop",   m_op,   16'h0000);
        step();
        chk("lit_jr_op",    m_op,   16'h1040);
        chk("lit_jr_pcn",   m_pcn,  16'h0041);

        // Wrap through FFFF
        wait_ir_vld();
        jr_sel = 1'b1; jmpr = 16'hFFFF;
        step();
        clear_redir();
        chk("lit_wrap_addr", m_addr, 16'hFFFF);
        step();
        chk("lit_wrap_op",   m_op,   16'h0FFF);
        chk("lit_wrap_pcn",  m_pcn,  16'h0000);
        step();
        chk("lit_wrap_op2",  m_op,   16'h1000);

        // Halt, stay halted, then restart from reset
        wait_ir_vld();
        pc_sel = 2'b11;
        step();
        clear_redir();
        chk("lit_halt",     {15'b0, m_halted}, 16'h0001);
        for (int i = 0; i < 5; i++) step();
        chk("lit_halt_op",  m_op, 16'h0000);
        chk("lit_halt_req", {15'b0, m_req()}, 16'h0000);
        do_reset();
        step(); step();
        chk("lit_restart",  m_op, 16'h1000);

        // Randomized wait states, redirects and resets
        prev_redir = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            clear_redir();
            ack_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0 || (m_halted && $urandom_range(0, 7) == 0)) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                prev_redir = 1'b0;
                continue;
            end
            if (m_req() && !m_killed && m_ir_vld && !prev_redir && $urandom_range(0, 5) == 0) begin
                kind = $urandom_range(0, 19);
                r8   = 8'($urandom);
                r11  = 11'($urandom);
                jmp8  = {{8{r8[7]}}, r8};
                jmp11 = {{5{r11[10]}}, r11};
                jmpr  = 16'($urandom);
                if (kind == 0)      pc_sel = 2'b11;
                else if (kind < 6)  begin jr_sel = 1'b1; pc_sel = 2'($urandom); end
                else if (kind < 12) pc_sel = 2'b01;
                else                pc_sel = 2'b10;
                prev_redir = 1'b1;
            end else begin
                prev_redir = 1'b0;
            end
            step();
        end
        clear_redir();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
